// File: rtl/trig_sequencer_pkg.sv
// trig_seq_pkg: shared FSM state encoding and timing constants for the
// trig_sequencer step sequencer and its pattern store.
package trig_seq_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GATE_WAIT = 2'd1,
    GATE_HIGH = 2'd2,
    GATE_LOW  = 2'd3
  } seq_state_t;

  // Shortest slot we will play; leaves room for a 1-cycle gate plus the guard.
  localparam int SEQ_MIN_PERIOD = 4;
  // Low cycles always left at the end of a slot so the voice re-arms its edge detector.
  localparam int SEQ_GATE_GUARD = 2;

endpackage

// File: rtl/trig_sequencer_if.sv
// trig_sequencer_if: pattern write bus from the control register bank plus
// the trigger/pitch bus towards one voice instance.
// master = register bank / voice side, slave = sequencer.
interface trig_sequencer_if #(
  parameter int NUM_STEPS     = 16,
  parameter int FREQ_RES_BITS = 8
);
  logic                         wr_en;
  logic [$clog2(NUM_STEPS)-1:0] wr_addr;
  logic                         wr_active;
  logic [FREQ_RES_BITS-1:0]     wr_freq;

  logic                         trig;
  logic [FREQ_RES_BITS-1:0]     freq;
  logic [$clog2(NUM_STEPS)-1:0] step_idx;
  logic                         step_strobe;

  modport master (
    output wr_en, wr_addr, wr_active, wr_freq,
    input  trig, freq, step_idx, step_strobe
  );

  modport slave (
    input  wr_en, wr_addr, wr_active, wr_freq,
    output trig, freq, step_idx, step_strobe
  );
endinterface

// File: rtl/trig_sequencer_pattern_ram.sv
// seq_pattern_ram: NUM_STEPS x {active, freq} register file with one write
// port and one registered read port. A read and write to the same address in
// the same cycle returns the old contents.
module seq_pattern_ram #(
  parameter int NUM_STEPS     = 16,
  parameter int FREQ_RES_BITS = 8
) (
  input  logic                         mclk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [$clog2(NUM_STEPS)-1:0] wr_addr,
  input  logic [FREQ_RES_BITS:0]       wr_data,
  input  logic                         rd_en,
  input  logic [$clog2(NUM_STEPS)-1:0] rd_addr,
  output logic [FREQ_RES_BITS:0]       rd_data
);

  logic [FREQ_RES_BITS:0] mem [NUM_STEPS];

  // Clear on reset; otherwise write and registered read (old data on collision).
  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STEPS; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/trig_sequencer.sv
// trig_sequencer: plays a NUM_STEPS pattern at a programmable step period and
// shapes gate pulses for the oneshot voice envelopers.
// Optional feature macro: TRIG_SEQUENCER_SWING_EN (adds swing input, delays
// the gate on odd steps).
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   IDLE      | stopped; trig low, step 0 prefetched every cycle
//   GATE_WAIT | odd-step swing delay before the gate rises
//   GATE_HIGH | trig high, gate down-counter running
//   GATE_LOW  | trig low until the slot down-counter reaches 0
module trig_sequencer
  import trig_seq_pkg::*;
#(
  parameter int NUM_STEPS     = 16,
  parameter int FREQ_RES_BITS = 8,
  parameter int PERIOD_BITS   = 24
) (
  input  logic                         mclk,
  input  logic                         rst_n,
  input  logic                         run,
  input  logic [PERIOD_BITS-1:0]       step_period,
  input  logic [PERIOD_BITS-1:0]       gate_len,
  input  logic [$clog2(NUM_STEPS)-1:0] last_step,
`ifdef TRIG_SEQUENCER_SWING_EN
  input  logic [PERIOD_BITS-1:0]       swing,
`endif
  trig_sequencer_if.slave              bus
);

  localparam int IDX_BITS = $clog2(NUM_STEPS);
  localparam logic [PERIOD_BITS-1:0] MIN_P = PERIOD_BITS'(SEQ_MIN_PERIOD);
  localparam logic [PERIOD_BITS-1:0] GUARD = PERIOD_BITS'(SEQ_GATE_GUARD);

  seq_state_t               state_q;
  logic [PERIOD_BITS-1:0]   cnt_q, gcnt_q, ghold_q;
  logic [IDX_BITS-1:0]      step_idx_q, fetch_idx_q;
  logic [FREQ_RES_BITS-1:0] freq_q;
  logic                     trig_q, strobe_q;

  logic                     rd_en;
  logic [IDX_BITS-1:0]      rd_addr, next_idx;
  logic [FREQ_RES_BITS:0]   rd_data;
  logic                     rd_active;
  logic [FREQ_RES_BITS-1:0] rd_freq;
  logic [PERIOD_BITS-1:0]   p_eff, wait_len, gate_room, g_eff;
  logic                     slot_start;

  // The next slot's entry is fetched one cycle ahead (at count 1, or every
  // cycle while stopped) so the registered read is ready at the slot edge.
  assign next_idx   = (step_idx_q >= last_step) ? '0 : step_idx_q + IDX_BITS'(1);
  assign rd_en      = (state_q == IDLE) || !run || (cnt_q == PERIOD_BITS'(1));
  assign rd_addr    = ((state_q == IDLE) || !run) ? '0 : next_idx;
  assign rd_active  = rd_data[FREQ_RES_BITS];
  assign rd_freq    = rd_data[FREQ_RES_BITS-1:0];
  assign slot_start = run && ((state_q == IDLE) || (cnt_q == '0));

  assign p_eff = (step_period < MIN_P) ? MIN_P : step_period;

`ifdef TRIG_SEQUENCER_SWING_EN
  logic [PERIOD_BITS-1:0] wait_max;
  assign wait_max = p_eff - GUARD - PERIOD_BITS'(1);
  assign wait_len = fetch_idx_q[0] ? ((swing < wait_max) ? swing : wait_max) : '0;
`else
  assign wait_len = '0;
`endif

  assign gate_room = p_eff - GUARD - wait_len;
  assign g_eff     = (gate_len < gate_room) ? gate_len : gate_room;

  seq_pattern_ram #(
    .NUM_STEPS    (NUM_STEPS),
    .FREQ_RES_BITS(FREQ_RES_BITS)
  ) u_ram (
    .mclk   (mclk),
    .rst_n  (rst_n),
    .wr_en  (bus.wr_en),
    .wr_addr(bus.wr_addr),
    .wr_data({bus.wr_active, bus.wr_freq}),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  // Sequencer FSM: slot timing, gate shaping and registered outputs.
  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gcnt_q      <= '0;
      ghold_q     <= '0;
      step_idx_q  <= '0;
      fetch_idx_q <= '0;
      freq_q      <= '0;
      trig_q      <= 1'b0;
      strobe_q    <= 1'b0;
    end else begin
      if (rd_en) fetch_idx_q <= rd_addr;
      strobe_q <= 1'b0;
      if (!run) begin
        state_q    <= IDLE;
        trig_q     <= 1'b0;
        step_idx_q <= '0;
        cnt_q      <= '0;
        gcnt_q     <= '0;
      end else if (slot_start) begin
        strobe_q   <= 1'b1;
        step_idx_q <= fetch_idx_q;
        freq_q     <= rd_freq;
        cnt_q      <= p_eff - PERIOD_BITS'(1);
        if (rd_active && (g_eff != '0)) begin
          if (wait_len != '0) begin
            state_q <= GATE_WAIT;
            trig_q  <= 1'b0;
            gcnt_q  <= wait_len - PERIOD_BITS'(1);
            ghold_q <= g_eff;
          end else begin
            state_q <= GATE_HIGH;
            trig_q  <= 1'b1;
            gcnt_q  <= g_eff - PERIOD_BITS'(1);
          end
        end else begin
          state_q <= GATE_LOW;
          trig_q  <= 1'b0;
        end
      end else begin
        cnt_q <= cnt_q - PERIOD_BITS'(1);
        case (state_q)
          GATE_WAIT: begin
            if (gcnt_q == '0) begin
              state_q <= GATE_HIGH;
              trig_q  <= 1'b1;
              gcnt_q  <= ghold_q - PERIOD_BITS'(1);
            end else begin
              gcnt_q <= gcnt_q - PERIOD_BITS'(1);
            end
          end
          GATE_HIGH: begin
            if (gcnt_q == '0) begin
              state_q <= GATE_LOW;
              trig_q  <= 1'b0;
            end else begin
              gcnt_q <= gcnt_q - PERIOD_BITS'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.trig        = trig_q;
  assign bus.freq        = freq_q;
  assign bus.step_idx    = step_idx_q;
  assign bus.step_strobe = strobe_q;

endmodule

// File: tb/tb_trig_sequencer.sv
// tb_trig_sequencer: directed stimulus with a slot scoreboard. Each expected
// slot (index, freq, length, gate high time, gate rise offset) is queued
// before playback; a negedge monitor pops one entry per step_strobe.
module tb_trig_sequencer;

  localparam int NS = 16;
  localparam int FB = 8;
  localparam int PB = 24;

  logic          mclk = 1'b0;
  logic          rst_n;
  logic          run;
  logic [PB-1:0] step_period;
  logic [PB-1:0] gate_len;
  logic [3:0]    last_step;
`ifdef TRIG_SEQUENCER_SWING_EN
  logic [PB-1:0] swing;
`endif

  trig_sequencer_if #(.NUM_STEPS(NS), .FREQ_RES_BITS(FB)) bus ();

  trig_sequencer #(.NUM_STEPS(NS), .FREQ_RES_BITS(FB), .PERIOD_BITS(PB)) dut (
    .mclk       (mclk),
    .rst_n      (rst_n),
    .run        (run),
    .step_period(step_period),
    .gate_len   (gate_len),
    .last_step  (last_step),
`ifdef TRIG_SEQUENCER_SWING_EN
    .swing      (swing),
`endif
    .bus        (bus)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    int idx;
    int freq;
    int period;
    int high;
    int rise;
    bit chk;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   fr[4] = '{48, 52, 55, 60};

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: one scoreboard entry per slot; slot shape checked at the next strobe.
  exp_t cur;
  bit   in_slot = 1'b0;
  int   slot_len = 0, slot_high = 0, rise_off = -1;
  always @(negedge mclk) begin
    if (bus.step_strobe === 1'b1) begin
      if (in_slot && cur.chk) begin
        check($sformatf("slot%0d_len", cur.idx), slot_len, cur.period);
        check($sformatf("slot%0d_high", cur.idx), slot_high, cur.high);
        check($sformatf("slot%0d_rise", cur.idx), rise_off, cur.rise);
      end
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_strobe: got strobe at step %0d, required none", bus.step_idx);
        in_slot = 1'b0;
      end else begin
        cur = exp_q.pop_front();
        check("strobe_idx", int'(bus.step_idx), cur.idx);
        check($sformatf("strobe%0d_freq", cur.idx), int'(bus.freq), cur.freq);
        in_slot = 1'b1;
      end
      slot_len  = 0;
      slot_high = 0;
      rise_off  = -1;
    end
    if (in_slot) begin
      if (bus.trig === 1'b1) begin
        if (rise_off < 0) rise_off = slot_len;
        slot_high++;
      end
      slot_len++;
    end
  end

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic push(input int idx, input int f, input int p, input int h,
                      input int r, input bit chk);
    exp_t e;
    e.idx = idx; e.freq = f; e.period = p; e.high = h; e.rise = r; e.chk = chk;
    exp_q.push_back(e);
  endtask

  task automatic write_step(input int addr, input bit act, input int f);
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 4'(addr);
    bus.wr_active = act;
    bus.wr_freq   = 8'(f);
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_strobes(input int n);
    int seen = 0;
    for (int c = 0; c < 2000 && seen < n; c++) begin
      tick();
      if (bus.step_strobe === 1'b1) seen++;
    end
    check("strobe_wait", seen, n);
  endtask

  task automatic stop_and_check(input string name);
    run = 1'b0;
    tick();
    check({name, "_stop_trig"}, int'(bus.trig), 0);
    check({name, "_stop_idx"}, int'(bus.step_idx), 0);
    repeat (3) tick();
  endtask

  task automatic run_and_stop(input string name, input int n, input int extra);
    run = 1'b1;
    wait_strobes(n);
    repeat (extra) tick();
    stop_and_check(name);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    run           = 1'b0;
    step_period   = 24'd20;
    gate_len      = 24'd8;
    last_step     = 4'd3;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_active = 1'b0;
    bus.wr_freq   = '0;
`ifdef TRIG_SEQUENCER_SWING_EN
    swing         = '0;
`endif
    repeat (3) tick();
    rst_n = 1'b1;

    // Stopped after reset: every output stays at zero.
    for (int c = 0; c < 100; c++) begin
      tick();
      check("idle_outputs", int'({bus.trig, bus.freq, bus.step_idx, bus.step_strobe}), 0);
    end

    // Four active steps, P=20, G=8, wrap after step 3.
    for (int i = 0; i < 4; i++) write_step(i, 1'b1, fr[i]);
    repeat (2) tick();
    for (int i = 0; i < 4; i++) push(i, fr[i], 20, 8, 0, 1'b1);
    push(0, 48, 20, 8, 0, 1'b0);
    run = 1'b1;
    tick();
    check("latency_strobe", int'(bus.step_strobe), 1);
    check("latency_trig", int'(bus.trig), 1);
    wait_strobes(4);
    repeat (3) tick();
    stop_and_check("basic");

    // Gate longer than the slot is clipped to P-2; wrap after step 1.
    gate_len  = 24'd50;
    last_step = 4'd1;
    push(0, 48, 20, 18, 0, 1'b1);
    push(1, 52, 20, 18, 0, 1'b1);
    push(0, 48, 20, 18, 0, 1'b0);
    run_and_stop("clip", 3, 2);

    // Period below minimum runs at 4 cycles with a 2-cycle gate.
    step_period = 24'd2;
    gate_len    = 24'd8;
    last_step   = 4'd3;
    for (int i = 0; i < 4; i++) push(i, fr[i], 4, 2, 0, 1'b1);
    push(0, 48, 4, 2, 0, 1'b0);
    run_and_stop("minp", 5, 1);

    // Zero gate length: strobes and freq only.
    step_period = 24'd6;
    gate_len    = 24'd0;
    push(0, 48, 6, 0, -1, 1'b1);
    push(1, 52, 6, 0, -1, 1'b0);
    run_and_stop("nogate", 2, 2);

    // Step 2 inactive; stop mid-gate in slot 1, then restart from step 0.
    step_period = 24'd20;
    gate_len    = 24'd8;
    write_step(2, 1'b0, 55);
    repeat (2) tick();
    push(0, 48, 20, 8, 0, 1'b1);
    push(1, 52, 20, 8, 0, 1'b0);
    run = 1'b1;
    wait_strobes(2);
    repeat (5) tick();
    check("midgate_trig", int'(bus.trig), 1);
    run = 1'b0;
    tick();
    check("midstop_trig", int'(bus.trig), 0);
    check("midstop_idx", int'(bus.step_idx), 0);
    check("midstop_strobe", int'(bus.step_strobe), 0);
    check("midstop_freq_hold", int'(bus.freq), 52);
    repeat (4) tick();
    push(0, 48, 20, 8, 0, 1'b1);
    push(1, 52, 20, 8, 0, 1'b1);
    push(2, 55, 20, 0, -1, 1'b1);
    push(3, 60, 20, 8, 0, 1'b1);
    push(0, 48, 20, 8, 0, 1'b0);
    run = 1'b1;
    tick();
    check("restart_strobe", int'(bus.step_strobe), 1);
    check("restart_idx", int'(bus.step_idx), 0);
    wait_strobes(4);
    repeat (3) tick();
    stop_and_check("restart");

`ifdef TRIG_SEQUENCER_SWING_EN
    // Swing: odd steps rise 4 cycles late with full gate length.
    write_step(2, 1'b1, 55);
    repeat (2) tick();
    swing = 24'd4;
    push(0, 48, 20, 8, 0, 1'b1);
    push(1, 52, 20, 8, 4, 1'b1);
    push(2, 55, 20, 8, 0, 1'b1);
    push(3, 60, 20, 8, 4, 1'b1);
    push(0, 48, 20, 8, 0, 1'b0);
    run_and_stop("swing", 5, 3);
    swing = '0;
`endif

    // Reset wins over run and a pattern write in the same cycle.
    rst_n         = 1'b0;
    run           = 1'b1;
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 4'd0;
    bus.wr_active = 1'b1;
    bus.wr_freq   = 8'd99;
    tick();
    check("rst_strobe", int'(bus.step_strobe), 0);
    check("rst_trig", int'(bus.trig), 0);
    check("rst_freq", int'(bus.freq), 0);
    bus.wr_en = 1'b0;
    push(0, 0, 20, 0, -1, 1'b0);
    rst_n = 1'b1;
    tick();
    check("postrst_strobe", int'(bus.step_strobe), 1);
    check("postrst_trig", int'(bus.trig), 0);
    check("postrst_freq", int'(bus.freq), 0);
    repeat (2) tick();
    stop_and_check("postrst");

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/trig_sequencer.md
# trig_sequencer

Step sequencer that drives the trigger/gate and pitch inputs of the oneshot drum voices. Holds a NUM_STEPS-entry pattern (active flag + frequency code per step) and plays it at a programmable step period, producing gate pulses shaped for the voice envelopers. Each gate is high for the sustain time, then low long enough for the receiver's rising-edge detector to re-arm. Sits between the control register bank (pattern writes, tempo, run) and one voice instance.

## Interface
- NUM_STEPS, 16: pattern length capacity; power of two, ≥2.
- FREQ_RES_BITS, 8: width of frequency code; must match voice player.
- PERIOD_BITS, 24: width of step_period and gate_len.
- mclk  input  1  master clock (256x sample rate).
- rst_n  input  1  reset; synchronous, active-low.
- run  input  1  level: 1 = play, 0 = stop.
- step_period  input  PERIOD_BITS  mclk cycles per step slot.
- gate_len  input  PERIOD_BITS  gate high time in mclk cycles; 0 = no gate.
- last_step  input  $clog2(NUM_STEPS)  index after which playback wraps to 0.
- wr_en  input  1  pattern write strobe.
- wr_addr  input  $clog2(NUM_STEPS)  step index to write.
- wr_active  input  1  step fires a gate.
- wr_freq  input  FREQ_RES_BITS  frequency code for step.
- trig  output  1  gate to voice trigger input.
- freq  output  FREQ_RES_BITS  frequency code of current step.
- step_idx  output  $clog2(NUM_STEPS)  current step.
- step_strobe  output  1  one-cycle pulse at each slot start.

## Operation
- States: IDLE, GATE_WAIT, GATE_HIGH, GATE_LOW.
- IDLE: trig=0, slot counter 0, step_idx=0. When run=1, the first slot (step 0) starts next cycle.
- Slot start, cycle S:
  - step_strobe=1.
  - step_idx, freq, active are registered from the pattern.
  - step_period and gate_len are latched; values are not re-sampled mid-slot.
- Effective period: P = max(step_period, 4).
- Effective gate: G = min(gate_len, P-2). The 2-cycle guard guarantees ≥2 low cycles before the next slot.
- State after slot start:
  - active=1 and G>0: GATE_HIGH. trig=1 from S through S+G-1, then GATE_LOW.
  - active=0 or G=0: GATE_LOW directly; trig stays 0.
- GATE_LOW lasts until the slot counter reaches P-1. The next slot starts at S+P.
- Step advance: next index = (step_idx ≥ last_step) ? 0 : step_idx+1. A reduced last_step therefore wraps at the next slot boundary.
- freq holds its value across the slot and through the gate release; it changes only at slot start.
- Pattern writes are accepted in any state.
  - A write to step k is used the next time k is read.
  - If a write to the step being fetched lands in the same cycle as the fetch, the old value is used.
- run falling: the next cycle gives IDLE, trig=0, step_idx=0; freq holds its last value.
- run rising restarts at step 0.

## Timing
- Reset values: trig=0, freq=0, step_idx=0, step_strobe=0, state IDLE, all pattern entries inactive with freq 0.
- Reset takes priority over run and wr_en in the same cycle.
- All outputs are registered.
- Latency: run sampled high at cycle C gives the first step_strobe and trig at C+1.
- Minimum trig low time between consecutive active steps is 2 cycles. The receiver's edge detector needs 1.

## Configuration
- TRIG_SEQUENCER_SWING_EN defined:
  - Adds input swing [PERIOD_BITS-1:0].
  - On odd step indices, the gate rise is delayed: state GATE_WAIT for W = min(swing, P-3) cycles after slot start.
  - Gate length in those slots is G = min(gate_len, P-2-W).
  - freq and step_strobe still update at slot start.
- Not defined: no swing port; GATE_WAIT is unreachable; even and odd steps are identical.

## Structure
- Package trig_seq_pkg holds:
  - enum seq_state_t.
  - localparams SEQ_MIN_PERIOD=4 and SEQ_GATE_GUARD=2.
- Sub-module seq_pattern_ram:
  - NUM_STEPS × (1+FREQ_RES_BITS) register file.
  - Synchronous active-low clear, one write port, one registered read port.
  - Read-before-write on address collision.

## Test plan
- Reset, then run=0: trig, freq, step_idx, step_strobe all 0 for 100 cycles.
- Write steps 0–3 active, freq 48/52/55/60; step_period=20, gate_len=8, last_step=3; run=1:
  - step_strobe every 20 cycles; trig high 8 cycles per slot.
  - freq sequence 48, 52, 55, 60, 48.
- gate_len=50, step_period=20: trig high 18 cycles, low 2, each slot.
- Step 2 inactive: no trig in slot 2; step_strobe and freq=55 still update.
- Deassert run mid-gate (cycle 5 of slot 1): trig=0 and step_idx=0 next cycle. Reassert: slot restarts at step 0.
- With TRIG_SEQUENCER_SWING_EN, swing=4, P=20, gate_len=8:
  - Odd slots: trig rises at S+4 and is high 8 cycles.
  - Even slots: trig rises at S.
